// File: rtl/regfile_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_op_sequencer
//  Description : Multi-cycle command sequencer in front of the 8-entry
//                register file (R1-R4, S1-S4). Accepts one command per
//                valid/ready handshake and drives read selects, function
//                select, active-low write enables and the write-data mux.
//                Supports LDI/MOV/CLR/INC/DEC, repeated increment (ADDK)
//                and a 3-step SWAP through a temporary register.
//                Optional macro SEQ_OPCOUNT_EN adds the OpCount output.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_op_sequencer #(
    parameter logic [2:0] TMP_REG = 3'd7,
    parameter int         MAX_K   = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [2:0]  CmdOp,
    input  logic [2:0]  CmdDst,
    input  logic [2:0]  CmdSrc,
    input  logic [15:0] CmdImm,
    output logic [2:0]  OutASel,
    output logic [2:0]  OutBSel,
    output logic [2:0]  FunSel,
    output logic [3:0]  RegSel,
    output logic [3:0]  ScrSel,
    output logic        IMuxSel,
    output logic [15:0] IData,
    output logic        Busy,
    output logic        Done,
`ifdef SEQ_OPCOUNT_EN
    output logic        Err,
    output logic [15:0] OpCount
`else
    output logic        Err
`endif
);

    // Command opcodes
    localparam logic [2:0] c_OP_LDI  = 3'd0;
    localparam logic [2:0] c_OP_MOV  = 3'd1;
    localparam logic [2:0] c_OP_CLR  = 3'd2;
    localparam logic [2:0] c_OP_INC  = 3'd3;
    localparam logic [2:0] c_OP_DEC  = 3'd4;
    localparam logic [2:0] c_OP_ADDK = 3'd5;
    localparam logic [2:0] c_OP_SWAP = 3'd6;
    localparam logic [2:0] c_OP_RSVD = 3'd7;

    // Regfile function codes
    localparam logic [2:0] c_FUN_DEC  = 3'b000;
    localparam logic [2:0] c_FUN_INC  = 3'b001;
    localparam logic [2:0] c_FUN_LOAD = 3'b010;
    localparam logic [2:0] c_FUN_CLR  = 3'b011;

    // FSM states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Repeat ceiling, itself limited to what a 4-bit count can express
    localparam logic [3:0] c_MAX_K = (MAX_K > 15) ? 4'd15 : 4'(MAX_K);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [2:0]  r_op;
    logic [2:0]  r_dst;
    logic [2:0]  r_src;
    logic [15:0] r_imm;
    logic [3:0]  r_k;
    logic [3:0]  r_step;
    logic        r_err;

    logic        w_accept;
    logic        w_cmd_err;
    logic [3:0]  w_k;
    logic [3:0]  w_last_step;
    logic        w_last;
    logic        w_wr_en;
    logic [2:0]  w_wr_id;
    logic [1:0]  w_bit;

    assign w_accept = CmdValid && (r_state == c_ST_IDLE);

    // Reserved opcode, or a SWAP whose operands alias each other or the temp
    assign w_cmd_err = (CmdOp == c_OP_RSVD) ||
                       ((CmdOp == c_OP_SWAP) &&
                        ((CmdSrc == CmdDst) || (CmdSrc == TMP_REG) || (CmdDst == TMP_REG)));

    assign w_k = (CmdImm[3:0] > c_MAX_K) ? c_MAX_K : CmdImm[3:0];

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command latch and EXEC step counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_op   <= 3'd0;
            r_dst  <= 3'd0;
            r_src  <= 3'd0;
            r_imm  <= 16'd0;
            r_k    <= 4'd0;
            r_step <= 4'd0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_op   <= CmdOp;
            r_dst  <= CmdDst;
            r_src  <= CmdSrc;
            r_imm  <= CmdImm;
            r_k    <= w_k;
            r_step <= 4'd0;
            r_err  <= w_cmd_err;
        end else if (r_state == c_ST_EXEC) begin
            r_step <= r_step + 4'd1;
        end
    end

    // Index of the final EXEC cycle for the latched command
    always_comb begin
        w_last_step = 4'd0;
        if (!r_err) begin
            case (r_op)
                c_OP_ADDK: w_last_step = (r_k == 4'd0) ? 4'd0 : (r_k - 4'd1);
                c_OP_SWAP: w_last_step = 4'd2;
                default:   w_last_step = 4'd0;
            endcase
        end
    end

    assign w_last = (r_step == w_last_step);

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_next_state = c_ST_EXEC;
            c_ST_EXEC: if (w_last)   w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Output decode: per-op selects and the single active-low write enable
    always_comb begin
        CmdReady = (r_state == c_ST_IDLE);
        Busy     = (r_state == c_ST_EXEC) || (r_state == c_ST_DONE);
        Done     = (r_state == c_ST_DONE);
        Err      = (r_state == c_ST_DONE) && r_err;
        OutASel  = r_src;
        OutBSel  = r_dst;
        FunSel   = c_FUN_LOAD;
        IMuxSel  = 1'b0;
        IData    = r_imm;
        w_wr_en  = 1'b0;
        w_wr_id  = r_dst;
        RegSel   = 4'b1111;
        ScrSel   = 4'b1111;
        w_bit    = 2'd0;

        if ((r_state == c_ST_EXEC) && !r_err) begin
            case (r_op)
                c_OP_LDI: begin
                    w_wr_en = 1'b1;
                end
                c_OP_MOV: begin
                    IMuxSel = 1'b1;
                    w_wr_en = 1'b1;
                end
                c_OP_CLR: begin
                    FunSel  = c_FUN_CLR;
                    w_wr_en = 1'b1;
                end
                c_OP_INC: begin
                    FunSel  = c_FUN_INC;
                    w_wr_en = 1'b1;
                end
                c_OP_DEC: begin
                    FunSel  = c_FUN_DEC;
                    w_wr_en = 1'b1;
                end
                c_OP_ADDK: begin
                    // A zero count still spends one EXEC cycle, but writes nothing
                    FunSel  = c_FUN_INC;
                    w_wr_en = (r_k != 4'd0);
                end
                c_OP_SWAP: begin
                    IMuxSel = 1'b1;
                    w_wr_en = 1'b1;
                    case (r_step)
                        4'd0: begin
                            OutASel = r_src;
                            w_wr_id = TMP_REG;
                        end
                        4'd1: begin
                            OutASel = r_dst;
                            w_wr_id = r_src;
                        end
                        default: begin
                            OutASel = TMP_REG;
                            w_wr_id = r_dst;
                        end
                    endcase
                end
                default: begin
                    w_wr_en = 1'b0;
                end
            endcase
        end

        // id 0..3 map to RegSel bit 3..0, id 4..7 map to ScrSel bit 3..0
        w_bit = ~w_wr_id[1:0];
        if (w_wr_en) begin
            if (w_wr_id[2]) begin
                ScrSel[w_bit] = 1'b0;
            end else begin
                RegSel[w_bit] = 1'b0;
            end
        end
    end

`ifdef SEQ_OPCOUNT_EN
    logic [15:0] r_opcount;

    // Count successful completions, saturating at all-ones
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_opcount <= 16'd0;
        end else if ((r_state == c_ST_DONE) && !r_err && (r_opcount != 16'hFFFF)) begin
            r_opcount <= r_opcount + 16'd1;
        end
    end

    assign OpCount = r_opcount;
`endif

endmodule
`default_nettype wire
